l2_line_arbiter: RTL and testbench

- Shares the single L2 cache line port between the I-cache and the D-cache miss/write-back ports.
- Latches the granted request, then drives one L2 transaction at a time.
- Returns the L2 response and line only to the requester that owns the transaction.
- Uses round-robin on contention, raises a CPU stall while any requester is waiting, and flags hung transactions with a watchdog.

---
 rtl/l2_line_arbiter_pkg.sv | 18 +
 rtl/arb_watchdog.sv | 32 +++
 rtl/l2_line_arbiter.sv | 124 ++++++++++++
 tb/tb_l2_line_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_line_arbiter_pkg.sv
// Shared types for the L2 line-port arbiter: FSM states, requester ids and line geometry.
package l2_line_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_XFER,
    D_XFER
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

  // 32-byte lines: the low five address bits select a byte within the line.
  localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/arb_watchdog.sv
// Per-transaction watchdog: counts cycles spent in a transfer and raises a sticky
// error once the count reaches TIMEOUT. TIMEOUT of 0 keeps the flag low forever.
module arb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic timeout_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // The flag sets on the same edge the counter lands on LIMIT; the counter then saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      timeout_err <= 1'b0;
    end else if (clear) begin
      count <= '0;
    end else if (active && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
      if ((TIMEOUT != 0) && ((count + CNT_W'(1)) == LIMIT))
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: rtl/l2_line_arbiter.sv
// Shares the single L2 line port between the I-cache and D-cache, one transaction at a time,
// with round-robin on contention and a watchdog on hung L2 transfers.
module l2_line_arbiter
  import l2_line_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_resp_o,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_line_i,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_resp_o,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              stall,
  output logic              timeout_err
);

  // Falls back to deriving the offset from LINE_W when the line is not the standard 32 bytes.
  localparam int OFFSET_BITS = ((LINE_W / 8) == (1 << LINE_OFFSET_BITS)) ?
                               LINE_OFFSET_BITS : $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_BITS;

  arb_state_t        state;
  arb_src_t          last_grant;
  logic [LINE_W-1:0] i_line_q;
  logic [LINE_W-1:0] d_line_q;
  logic              i_req;
  logic              d_req;
  logic              grant;
  logic              grant_d;
  logic [ADDR_W-1:0] grant_addr;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the D side wins only if the I side owned the previous grant.
  always_comb begin
    grant      = (state == IDLE) && (i_req || d_req);
    grant_d    = d_req && (!i_req || (last_grant == SRC_I));
    grant_addr = (grant_d ? d_address : i_address) & LINE_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_D;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
      i_line_q   <= '0;
      d_line_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            l2_address <= grant_addr;
            l2_wdata   <= d_line_i;
            if (grant_d) begin
              state      <= D_XFER;
              last_grant <= SRC_D;
              l2_write   <= d_write;
              l2_read    <= ~d_write;
            end else begin
              state      <= I_XFER;
              last_grant <= SRC_I;
              l2_read    <= 1'b1;
              l2_write   <= 1'b0;
            end
          end
        end
        I_XFER: begin
          if (l2_resp) begin
            state    <= IDLE;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            i_line_q <= l2_rdata;
          end
        end
        D_XFER: begin
          if (l2_resp) begin
            state    <= IDLE;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            d_line_q <= l2_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The completing cycle forwards l2_rdata straight through; afterwards the captured copy is shown.
  assign i_resp_o = (state == I_XFER) && l2_resp;
  assign d_resp_o = (state == D_XFER) && l2_resp;
  assign i_line_o = i_resp_o ? l2_rdata : i_line_q;
  assign d_line_o = d_resp_o ? l2_rdata : d_line_q;
  assign stall    = (i_read | d_read | d_write) & ~(i_resp_o | d_resp_o);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear      (grant),
    .active     (state != IDLE),
    .timeout_err(timeout_err)
  );

endmodule

// File: tb/tb_l2_line_arbiter.sv
// Directed bench for l2_line_arbiter: a table of single-requester transactions plus
// hand-written sequences for contention, mid-flight drop, watchdog and reset.
module tb_l2_line_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_line_o;
  logic              i_resp_o;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_line_i = '0;
  logic [LINE_W-1:0] d_line_o;
  logic              d_resp_o;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata = '0;
  logic              l2_resp = 1'b0;
  logic              stall;
  logic              timeout_err;

  always #5 clk = ~clk;

  l2_line_arbiter #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_line_o   (i_line_o),
    .i_resp_o   (i_resp_o),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_line_i   (d_line_i),
    .d_line_o   (d_line_o),
    .d_resp_o   (d_resp_o),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp),
    .stall      (stall),
    .timeout_err(timeout_err)
  );

  // The D cache must never ask for a read and a write-back together.
  always @(posedge clk) begin
    if (!rst) assert (!(d_read && d_write)) else $error("[TB] d_read and d_write both high");
  end

  typedef struct {
    logic              i_rd;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_line;
    logic [LINE_W-1:0] rdata;
    int                delay;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_d;
  } vec_t;

  vec_t              vecs[4];
  int                compared   = 0;
  int                mismatched = 0;
  logic [LINE_W-1:0] exp_i_line = '0;
  logic [LINE_W-1:0] exp_d_line = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                             input logic [LINE_W-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkLines(input string tag);
    checkOutput({tag, " i_line_o"}, i_line_o, exp_i_line);
    checkOutput({tag, " d_line_o"}, d_line_o, exp_d_line);
  endtask

  // One complete single-requester transaction; requester holds its request until the resp cycle.
  task automatic applyStimulus(input vec_t v, input string tag);
    i_read    = v.i_rd;
    d_read    = v.d_rd;
    d_write   = v.d_wr;
    i_address = v.i_addr;
    d_address = v.d_addr;
    d_line_i  = v.d_line;
    tick();
    checkOutput({tag, " l2_read"}, l2_read, !v.d_wr);
    checkOutput({tag, " l2_write"}, l2_write, v.d_wr);
    checkOutput({tag, " l2_address"}, l2_address, v.exp_addr);
    checkOutput({tag, " stall"}, stall, 1'b1);
    if (v.d_wr) checkOutput({tag, " l2_wdata"}, l2_wdata, v.d_line);
    for (int k = 1; k < v.delay; k++) begin
      tick();
      checkOutput({tag, " held strobe"}, l2_read | l2_write, 1'b1);
      checkOutput({tag, " held address"}, l2_address, v.exp_addr);
      checkOutput({tag, " early resp"}, {i_resp_o, d_resp_o}, 2'b00);
      if (v.d_wr) checkOutput({tag, " held wdata"}, l2_wdata, v.d_line);
    end
    l2_resp  = 1'b1;
    l2_rdata = v.rdata;
    #1;
    checkOutput({tag, " i_resp_o"}, i_resp_o, !v.exp_d);
    checkOutput({tag, " d_resp_o"}, d_resp_o, v.exp_d);
    checkOutput({tag, " stall at resp"}, stall, 1'b0);
    if (v.exp_d) exp_d_line = v.rdata;
    else exp_i_line = v.rdata;
    checkLines({tag, " passthrough"});
    tick();
    l2_resp  = 1'b0;
    l2_rdata = '0;
    i_read   = 1'b0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    #1;
    checkOutput({tag, " strobes dropped"}, {l2_read, l2_write}, 2'b00);
    checkOutput({tag, " resp after"}, {i_resp_o, d_resp_o}, 2'b00);
    checkLines({tag, " captured"});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    vecs[0] = '{i_rd: 1'b1, d_rd: 1'b0, d_wr: 1'b0, i_addr: 32'h0000_0064, d_addr: 32'h0,
                d_line: '0, rdata: {8{32'hAAAA_AAAA}}, delay: 5,
                exp_addr: 32'h0000_0060, exp_d: 1'b0};
    vecs[1] = '{i_rd: 1'b0, d_rd: 1'b0, d_wr: 1'b1, i_addr: 32'h0, d_addr: 32'h8000_0040,
                d_line: {8{32'h1234_5678}}, rdata: {8{32'h0BAD_F00D}}, delay: 3,
                exp_addr: 32'h8000_0040, exp_d: 1'b1};
    vecs[2] = '{i_rd: 1'b0, d_rd: 1'b1, d_wr: 1'b0, i_addr: 32'h0, d_addr: 32'h0000_107F,
                d_line: {8{32'hCAFE_0000}}, rdata: {8{32'h5555_5555}}, delay: 1,
                exp_addr: 32'h0000_1060, exp_d: 1'b1};
    vecs[3] = '{i_rd: 1'b1, d_rd: 1'b0, d_wr: 1'b0, i_addr: 32'hFFFF_FFFF, d_addr: 32'h0,
                d_line: '0, rdata: {8{32'h0F0F_1E1E}}, delay: 2,
                exp_addr: 32'hFFFF_FFE0, exp_d: 1'b0};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset l2_read", l2_read, 1'b0);
    checkOutput("reset l2_write", l2_write, 1'b0);
    checkOutput("reset l2_address", l2_address, '0);
    checkOutput("reset l2_wdata", l2_wdata, '0);
    checkOutput("reset resp", {i_resp_o, d_resp_o}, 2'b00);
    checkOutput("reset stall", stall, 1'b0);
    checkOutput("reset timeout_err", timeout_err, 1'b0);
    checkLines("reset");

    // A stray L2 completion while idle must not reach either cache.
    l2_resp  = 1'b1;
    l2_rdata = {8{32'hFFFF_0000}};
    #1;
    checkOutput("idle resp i_resp_o", i_resp_o, 1'b0);
    checkOutput("idle resp d_resp_o", d_resp_o, 1'b0);
    checkLines("idle resp");
    tick();
    l2_resp  = 1'b0;
    l2_rdata = '0;
    #1;
    checkLines("idle resp after");
    checkOutput("idle resp no strobe", {l2_read, l2_write}, 2'b00);

    // Contention from reset: both keep requesting, grants must alternate I, D, I, D.
    i_read    = 1'b1;
    d_read    = 1'b1;
    i_address = 32'h0000_011F;
    d_address = 32'h0000_021E;
    for (int g = 0; g < 4; g++) begin
      logic              is_d;
      logic [LINE_W-1:0] data;
      is_d = (g % 2) == 1;
      data = {8{32'hC0DE_0000 + 32'(g)}};
      tick();
      checkOutput("rr l2_read", l2_read, 1'b1);
      checkOutput("rr l2_address", l2_address, is_d ? 32'h0000_0200 : 32'h0000_0100);
      checkOutput("rr stall busy", stall, 1'b1);
      tick();
      checkOutput("rr stall wait", stall, 1'b1);
      l2_resp  = 1'b1;
      l2_rdata = data;
      #1;
      checkOutput("rr i_resp_o", i_resp_o, !is_d);
      checkOutput("rr d_resp_o", d_resp_o, is_d);
      if (is_d) exp_d_line = data;
      else exp_i_line = data;
      checkLines("rr passthrough");
      tick();
      l2_resp = 1'b0;
      if (g == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
      #1;
      checkOutput("rr strobe dropped", l2_read, 1'b0);
      checkOutput("rr stall idle", stall, g != 3);
      checkLines("rr captured");
    end

    for (int n = 0; n < 4; n++) applyStimulus(vecs[n], $sformatf("vec%0d", n));
    checkOutput("no timeout after table", timeout_err, 1'b0);

    // Requester drops one cycle after grant; the latched address must carry the transfer.
    i_read    = 1'b1;
    i_address = 32'h0000_0ABC;
    tick();
    tick();
    i_read    = 1'b0;
    i_address = 32'hDEAD_BEEF;
    tick();
    tick();
    checkOutput("drop l2_read", l2_read, 1'b1);
    checkOutput("drop l2_address", l2_address, 32'h0000_0AA0);
    checkOutput("drop stall", stall, 1'b0);
    l2_resp  = 1'b1;
    l2_rdata = {8{32'h7777_1111}};
    #1;
    checkOutput("drop i_resp_o", i_resp_o, 1'b1);
    exp_i_line = {8{32'h7777_1111}};
    checkLines("drop passthrough");
    tick();
    l2_resp = 1'b0;
    #1;
    checkOutput("drop strobe dropped", l2_read, 1'b0);
    checkLines("drop captured");

    // Watchdog: L2 stays silent, so the flag must rise exactly TIMEOUT cycles after the strobe.
    d_read    = 1'b1;
    d_address = 32'h0000_0040;
    tick();
    checkOutput("wd strobe", l2_read, 1'b1);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      checkOutput($sformatf("wd early cycle%0d", k), timeout_err, 1'b0);
    end
    tick();
    checkOutput("wd set", timeout_err, 1'b1);
    checkOutput("wd not aborted", l2_read, 1'b1);
    l2_resp  = 1'b1;
    l2_rdata = {8{32'h9999_2222}};
    #1;
    checkOutput("wd late d_resp_o", d_resp_o, 1'b1);
    exp_d_line = {8{32'h9999_2222}};
    tick();
    l2_resp = 1'b0;
    d_read  = 1'b0;
    #1;
    checkOutput("wd sticky after resp", timeout_err, 1'b1);
    tick();
    checkOutput("wd sticky idle", timeout_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    exp_i_line = '0;
    exp_d_line = '0;
    checkOutput("wd cleared by rst", timeout_err, 1'b0);
    checkLines("wd rst lines");

    // Reset two cycles into a D read; afterwards a lone I request gets the port.
    d_read    = 1'b1;
    d_address = 32'h0000_0300;
    tick();
    tick();
    tick();
    checkOutput("rstx in flight", l2_read, 1'b1);
    rst       = 1'b1;
    d_read    = 1'b0;
    i_read    = 1'b1;
    i_address = 32'h0000_0444;
    tick();
    checkOutput("rstx l2_read", l2_read, 1'b0);
    checkOutput("rstx l2_address", l2_address, '0);
    checkOutput("rstx d_resp_o", d_resp_o, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("rstx regrant l2_read", l2_read, 1'b1);
    checkOutput("rstx regrant address", l2_address, 32'h0000_0440);
    l2_resp  = 1'b1;
    l2_rdata = {8{32'h3C3C_A5A5}};
    #1;
    checkOutput("rstx i_resp_o", i_resp_o, 1'b1);
    checkOutput("rstx d_resp_o late", d_resp_o, 1'b0);
    tick();
    l2_resp = 1'b0;
    i_read  = 1'b0;
    #1;
    exp_i_line = {8{32'h3C3C_A5A5}};
    checkLines("rstx captured");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
